avmm_pio_out_ctrl: RTL
======================

Name: avmm_pio_out_ctrl

Overview:
Parametrised Avalon-MM output PIO, the successor to the fixed-width single-register output ports in the QSYS subsystem.
- Adds atomic SET/CLEAR/TOGGLE registers, so software drives individual lines (rail enables, resets, LEDs) without read-modify-write.
- Adds a hardware timed-pulse engine that inverts selected bits for a programmable number of clocks.
- Sits on an Avalon-MM slave behind the interconnect; out_port goes to board pins.

Parameters:
- WIDTH, 6, output bit count, legal 1..32.
- RESET_VALUE, 0, value of the base data register after reset, WIDTH bits.
- PULSE_W, 16, width of the pulse-length register/counter, legal 1..32.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- address  in  3  word register index.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational, zero wait states.
- out_port  out  WIDTH  pin outputs.
- pulse_busy  out  1  high while any pulse is active.

Behaviour:
- Reset: reset_n is asynchronous, active-low; clk is the clock.
- Reset values: data_out=RESET_VALUE, pulse_len=0, pulse_mask=0, pulse_cnt=0.
- Out of reset: out_port=RESET_VALUE and pulse_busy=0.
- Write qualifier: wr = chipselect & ~write_n. All register updates happen on the clk rising edge.
- Write field: wd = writedata[WIDTH-1:0]. Upper writedata bits are ignored.
- Register map by address, write effect / read value:
  - 0 DATA: data_out<=wd / reads data_out.
  - 1 SET: data_out<=data_out|wd / reads 0.
  - 2 CLEAR: data_out<=data_out&~wd / reads 0.
  - 3 TOGGLE: data_out<=data_out^wd / reads 0.
  - 4 PULSE_LEN: pulse_len<=writedata[PULSE_W-1:0] / reads pulse_len, zero-extended.
  - 5 PULSE: starts a pulse / reads pulse_mask, zero-extended.
  - 6 OUT: no write effect / reads out_port, zero-extended.
  - 7: no write effect / reads 0.
- readdata is decoded from address alone, independent of chipselect. Unused upper bits are 0.
- Output equation: out_port = data_out ^ pulse_mask, combinational from registers, glitch-free relative to clk.
- Pulse engine states:
  - IDLE: pulse_mask==0.
  - ACTIVE: pulse_mask!=0.
- PULSE write with wd!=0:
  - pulse_mask<=pulse_mask|wd and pulse_cnt<=pulse_len.
  - This holds in both IDLE and ACTIVE. A write in ACTIVE retriggers: the counter reloads and already-pulsing bits stay inverted.
- PULSE write with wd==0: no effect. The counter does not reload.
- ACTIVE with no PULSE write:
  - pulse_cnt!=0: pulse_cnt decrements by 1.
  - pulse_cnt==0: pulse_mask<=0, return to IDLE.
- Pulse timing: a write accepted at edge N inverts the bits from after edge N through edge N+pulse_len+1. That is pulse_len+1 cycles; pulse_len=0 gives a 1-cycle pulse.
- Writes to DATA/SET/CLEAR/TOGGLE during ACTIVE modify the base value. out_port reflects the new base XOR mask immediately.
- A PULSE_LEN write during ACTIVE does not affect the running count. It applies at the next PULSE write.
- pulse_busy = |pulse_mask.
- Reset asserted mid-pulse: immediate return to reset values. No residual inversion after reset_n deasserts.
- Only one register is written per cycle, so there are no simultaneous register conflicts. The counter reload has priority over the terminal-count clear in the same cycle.

Test Plan:
- Reset with RESET_VALUE=6'h2A, WIDTH=6 -> out_port=6'h2A, readdata@0=32'h2A, pulse_busy=0.
- DATA write 0x3F0 -> out_port=6'h30. SET 0x03 -> 6'h33. CLEAR 0x10 -> 6'h23. TOGGLE 0x21 -> 6'h02. Reads @1/@2/@3 return 0.
- pulse_len=4, data=0, PULSE write 0x01 at edge N -> out_port[0]=1 for exactly 5 cycles, then 0. pulse_busy matches. Read@5=1 during the pulse.
- Retrigger: pulse_len=4. PULSE 0x01 at N, PULSE 0x02 at N+2 -> bits 0 and 1 are both high until after edge N+7, both clear together.
- During a pulse on bit0 with data bit0=1: out bit0=0. SET 0x04 mid-pulse -> bit2=1 immediately. After expiry, out_port=6'h05.
- reset_n low asynchronously mid-pulse -> out_port=RESET_VALUE without a clock edge. PULSE write 0 -> no change, pulse_busy stays 0.

Source files
------------

// File: rtl/avmm_pio_out_ctrl.sv
// Avalon-MM output PIO with atomic SET/CLEAR/TOGGLE access and a timed-pulse
// engine that inverts selected output bits for a programmable number of clocks.
module avmm_pio_out_ctrl #(
    parameter int unsigned     WIDTH       = 6,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned     PULSE_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             pulse_busy
);

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_SET       = 3'd1;
    localparam logic [2:0] ADDR_CLEAR     = 3'd2;
    localparam logic [2:0] ADDR_TOGGLE    = 3'd3;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd4;
    localparam logic [2:0] ADDR_PULSE     = 3'd5;
    localparam logic [2:0] ADDR_OUT       = 3'd6;

    logic [WIDTH-1:0]   data_q,  data_d;
    logic [WIDTH-1:0]   mask_q,  mask_d;
    logic [PULSE_W-1:0] len_q,   len_d;
    logic [PULSE_W-1:0] cnt_q,   cnt_d;

    logic               wr;
    logic [WIDTH-1:0]   wd;
    logic               pulse_wr;
    logic               unused_writedata;

    assign wr       = chipselect & ~write_n;
    assign wd       = writedata[WIDTH-1:0];
    assign pulse_wr = wr && (address == ADDR_PULSE) && (wd != '0);

    // Upper writedata bits beyond WIDTH/PULSE_W are intentionally ignored.
    assign unused_writedata = ^writedata;

    // Register state; reset clears any pulse in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
            mask_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            mask_q <= mask_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
        end
    end

    // Next-state: register writes, then pulse retrigger or countdown/expiry.
    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        len_d  = len_q;
        cnt_d  = cnt_q;

        if (wr) begin
            case (address)
                ADDR_DATA:      data_d = wd;
                ADDR_SET:       data_d = data_q | wd;
                ADDR_CLEAR:     data_d = data_q & ~wd;
                ADDR_TOGGLE:    data_d = data_q ^ wd;
                ADDR_PULSE_LEN: len_d  = writedata[PULSE_W-1:0];
                default:        ;
            endcase
        end

        // Reload wins over terminal-count clear; a zero-mask PULSE write is a no-op.
        if (pulse_wr) begin
            mask_d = mask_q | wd;
            cnt_d  = len_q;
        end else if (mask_q != '0) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - PULSE_W'(1);
            end else begin
                mask_d = '0;
            end
        end
    end

    // Read mux, decoded from address alone with zero wait states.
    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_DATA:      readdata = 32'(data_q);
            ADDR_PULSE_LEN: readdata = 32'(len_q);
            ADDR_PULSE:     readdata = 32'(mask_q);
            ADDR_OUT:       readdata = 32'(data_q ^ mask_q);
            default:        readdata = 32'd0;
        endcase
    end

    // Pin drive: base value with pulsing bits inverted.
    assign out_port   = data_q ^ mask_q;
    assign pulse_busy = |mask_q;

endmodule
